// File: rtl/shift_sub_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int SIZE_DEF      = 8;
   localparam int LONG_SIZE_DEF = 2 * SIZE_DEF;

   // Fill bit for the divide-by-zero quotient (all ones at any width)
   localparam logic DZ_FILL = 1'b1;

endpackage

// File: rtl/shift_sub_divider_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, record the quotient bit.
module div_step #(
   parameter int SIZE     = 8,
   parameter int LongSize = 2 * SIZE
) (
   input  logic [SIZE-1:0]     i_r,
   input  logic [LongSize-1:0] i_dq,
   input  logic [SIZE-1:0]     i_d,
   output logic [SIZE-1:0]     o_r,
   output logic [LongSize-1:0] o_dq
);

   logic [SIZE:0] w_t;
   logic [SIZE:0] w_diff;
   logic          w_ge;

   always_comb begin
      w_t    = {i_r, i_dq[LongSize-1]};
      w_diff = w_t - {1'b0, i_d};
      w_ge   = (w_t >= {1'b0, i_d});
      o_r    = w_ge ? w_diff[SIZE-1:0] : w_t[SIZE-1:0];
      o_dq   = {i_dq[LongSize-2:0], w_ge};
   end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 2*SIZE-bit dividend by SIZE-bit divisor,
// one quotient bit per clock behind a start/busy/done handshake.
module shift_sub_divider
   import div_pkg::*;
#(
   parameter int SIZE     = SIZE_DEF,
   parameter int LongSize = 2 * SIZE
) (
   input  logic                clk,
   input  logic                rst,
   // Handshake: start is taken only on an edge where busy=0; operands are
   // sampled on that edge. done pulses one cycle when results update.
   input  logic                start,
   input  logic [LongSize-1:0] dividend,
   input  logic [SIZE-1:0]     divisor,
   output logic                busy,
   output logic                done,
   output logic [LongSize-1:0] quotient,
   output logic [SIZE-1:0]     remainder,
   output logic                dz,
   output state_t              o_dbg_state
);

   localparam int CNT_W = $clog2(LongSize);

   state_t                r_state;
   state_t                w_state_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [LongSize-1:0]   r_dq;
   logic [SIZE-1:0]       r_d;
   logic [SIZE-1:0]       r_r;
   logic                  r_done;
   logic [LongSize-1:0]   r_quotient;
   logic [SIZE-1:0]       r_remainder;
   logic                  r_dz;
   logic                  w_accept_run;
   logic                  w_last;
   logic [SIZE-1:0]       w_r_next;
   logic [LongSize-1:0]   w_dq_next;

   div_step #(
      .SIZE     (SIZE),
      .LongSize (LongSize)
   ) u_step (
      .i_r  (r_r),
      .i_dq (r_dq),
      .i_d  (r_d),
      .o_r  (w_r_next),
      .o_dq (w_dq_next)
   );

   always_comb begin
      w_state_next = r_state;
      w_accept_run = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && (divisor != '0)) begin
               w_accept_run = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (r_cnt == '0) begin
               w_last       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_dq        <= '0;
         r_d         <= '0;
         r_r         <= '0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dz        <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= 1'b0;
         if (r_state == IDLE) begin
            if (w_accept_run) begin
               r_dq  <= dividend;
               r_d   <= divisor;
               r_r   <= '0;
               r_cnt <= CNT_W'(LongSize - 1);
            end else if (start) begin
               // Zero divisor finishes on the accepting edge without iterating
               r_quotient  <= {LongSize{DZ_FILL}};
               r_remainder <= '0;
               r_dz        <= 1'b1;
               r_done      <= 1'b1;
            end
         end else begin
            r_dq <= w_dq_next;
            r_r  <= w_r_next;
            if (w_last) begin
               r_quotient  <= w_dq_next;
               r_remainder <= w_r_next;
               r_dz        <= 1'b0;
               r_done      <= 1'b1;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

   assign busy        = (r_state == RUN);
   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign dz          = r_dz;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and randomized checks for shift_sub_divider at default sizes.
module tb_shift_sub_divider;
   import div_pkg::*;

   localparam int SIZE     = 8;
   localparam int LongSize = 16;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [LongSize-1:0] dividend = '0;
   logic [SIZE-1:0]     divisor = '0;
   logic                busy;
   logic                done;
   logic [LongSize-1:0] quotient;
   logic [SIZE-1:0]     remainder;
   logic                dz;
   state_t              dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   shift_sub_divider #(.SIZE(SIZE), .LongSize(LongSize)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .dz          (dz),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [LongSize-1:0] dvd, input logic [SIZE-1:0] dvs);
      start    = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      edge1();
      start    = 1'b0;
      dividend = $urandom_range(0, 65535);
      divisor  = $urandom_range(0, 255);
   endtask

   // Waits (bounded) for done; edges counts edges after the current point.
   task automatic wait_done(output int edges);
      edges = 0;
      while (!done && edges < 40) begin
         edge1();
         edges++;
      end
      if (!done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [LongSize-1:0] dvd, input logic [SIZE-1:0] dvs, output int edges);
      start_op(dvd, dvs);
      wait_done(edges);
   endtask

   initial begin
      int edges;
      int busy_cycles;
      logic [LongSize-1:0] dvd;
      logic [SIZE-1:0]     dvs;
      logic [LongSize-1:0] exp_q;
      logic [SIZE-1:0]     exp_r;

      edge1();
      edge1();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_dz", dz, 0);
      check("rst_state", dbg_state, IDLE);
      rst = 1'b0;

      // 100/7 with latency and busy-width checks
      start_op(16'd100, 8'd7);
      check("t1_busy_after_accept", busy, 1);
      busy_cycles = 1;
      edges = 0;
      while (!done && edges < 40) begin
         edge1();
         edges++;
         if (busy) busy_cycles++;
      end
      check("t1_latency", edges, 16);
      check("t1_busy_cycles", busy_cycles, 16);
      check("t1_busy_at_done", busy, 0);
      check("t1_q", quotient, 14);
      check("t1_r", remainder, 2);
      check("t1_dz", dz, 0);
      edge1();
      check("t1_done_clears", done, 0);
      check("t1_q_hold", quotient, 14);

      run_op(16'hFFFF, 8'hFF, edges);
      check("t2_q", quotient, 16'h0101);
      check("t2_r", remainder, 0);
      run_op(16'd6, 8'd7, edges);
      check("t2b_q", quotient, 0);
      check("t2b_r", remainder, 6);

      // Zero divisor completes on the accepting edge
      start_op(16'd5, 8'd0);
      check("t3_done", done, 1);
      check("t3_busy", busy, 0);
      check("t3_q", quotient, 16'hFFFF);
      check("t3_r", remainder, 0);
      check("t3_dz", dz, 1);
      edge1();
      check("t3_done_clears", done, 0);
      check("t3_busy_stays_low", busy, 0);
      run_op(16'd9, 8'd3, edges);
      check("t3b_q", quotient, 3);
      check("t3b_dz", dz, 0);

      // Start during RUN is ignored; start in the done cycle is accepted
      start_op(16'd100, 8'd7);
      for (int i = 0; i < 5; i++) edge1();
      start_op(16'd50, 8'd5);
      check("t4_busy_after_ignored", busy, 1);
      wait_done(edges);
      check("t4_latency_unchanged", edges, 10);
      check("t4_q", quotient, 14);
      check("t4_r", remainder, 2);
      start_op(16'd50, 8'd5);
      check("t4_b2b_busy", busy, 1);
      check("t4_b2b_q_held", quotient, 14);
      wait_done(edges);
      check("t4_b2b_latency", edges, 16);
      check("t4_b2b_q", quotient, 10);
      check("t4_b2b_r", remainder, 0);

      // Reset mid-run aborts; start right after deassert is accepted
      start_op(16'd1000, 8'd9);
      for (int i = 0; i < 8; i++) edge1();
      rst = 1'b1;
      edge1();
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_q", quotient, 0);
      check("t5_r", remainder, 0);
      check("t5_dz", dz, 0);
      // Reset wins over a simultaneous start
      start = 1'b1;
      dividend = 16'd20;
      divisor = 8'd4;
      edge1();
      check("t5_rst_prio_busy", busy, 0);
      check("t5_rst_prio_done", done, 0);
      rst = 1'b0;
      run_op(16'd1000, 8'd9, edges);
      check("t5_latency", edges, 16);
      check("t5_q", quotient, 111);
      check("t5_r", remainder, 1);

      // Randomized sweep against an arithmetic reference
      for (int i = 0; i < 500; i++) begin
         dvd = 16'($urandom_range(0, 65535));
         dvs = 8'($urandom_range(0, 255));
         if (i == 0) dvs = 8'd1;
         if (i == 1) dvd = 16'd0;
         if (i == 2) dvs = 8'd0;
         run_op(dvd, dvs, edges);
         if (dvs == 0) begin
            exp_q = 16'hFFFF;
            exp_r = 8'd0;
         end else begin
            exp_q = dvd / 16'(dvs);
            exp_r = 8'(dvd % 16'(dvs));
         end
         check("rnd_q", quotient, exp_q);
         check("rnd_r", remainder, exp_r);
         check("rnd_dz", dz, (dvs == 0));
         if (dvs != 0) begin
            check("rnd_identity", 32'(quotient) * 32'(dvs) + 32'(remainder), 32'(dvd));
            check("rnd_r_lt_d", (remainder < dvs), 1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
